// File: rtl/datapath_v2_pkg.sv
// datapath_v2_pkg: control strobe struct, select enums and ALU function codes for datapath_v2.
package datapath_v2_pkg;
  typedef enum logic [2:0] {AluAdd, AluAdc, AluSub, AluAnd, AluOr, AluXor, AluPassB, AluShr} alu_functions_t;
  typedef enum logic {ImmShort, ImmLong} imm_sel_t;
  typedef enum logic {BReg, BImm} b_sel_t;
  typedef enum logic [1:0] {RwR7, RwRd, RwRa} rw_sel_t;
  typedef enum logic {WdAlu, WdBus} wd_sel_t;
  typedef enum logic [2:0] {PcLr, PcAlu, PcBus, Pc1, PcInt} pc_sel_t;
  typedef enum logic {LrPc1, LrBus} lr_sel_t;
  typedef struct packed {
    alu_functions_t AluFn;
    imm_sel_t ImmSel;
    b_sel_t BSel;
    rw_sel_t RwSel;
    wd_sel_t WdSel;
    pc_sel_t PcSel;
    lr_sel_t LrSel;
    logic RegWe;
    logic FlagWe;
    logic PcWe;
    logic IrWe;
    logic AluWe;
    logic MemEn;
    logic PcEn;
    logic LrEn;
    logic AluEn;
    logic LsPush;
    logic LsPop;
    logic LsClr;
    logic Reti;
  } dp_ctrl_t;
endpackage

// File: rtl/datapath_v2_link_stack.sv
// link_stack: circular return-address stack with sticky overflow/underflow flags.
module link_stack #(
  parameter int DATA_W = 16,
  parameter int LS_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [DATA_W-1:0] lr_in,
  output logic [DATA_W-1:0] lr,
  output logic              ovf,
  output logic              unf
);
  localparam int PW = $clog2(LS_DEPTH);
  logic [DATA_W-1:0] mem_q [LS_DEPTH];
  logic [PW-1:0] top_q, top_d, wr_idx;
  logic [PW:0] count_q, count_d;
  logic ovf_q, ovf_d, unf_q, unf_d, full, empty, repl, grow, shrink;
  // push+pop on a non-empty stack rewrites the top in place; on an empty one it is a plain push
  always_comb begin
    full = count_q == (PW+1)'(LS_DEPTH);
    empty = count_q == '0;
    repl = push & pop & ~empty;
    grow = push & ~repl;
    shrink = pop & ~push & ~empty;
    wr_idx = repl ? top_q : top_q + 1'b1;
    top_d = grow ? top_q + 1'b1 : shrink ? top_q - 1'b1 : top_q;
    count_d = grow & ~full ? count_q + 1'b1 : shrink ? count_q - 1'b1 : count_q;
    ovf_d = (grow & full) | (~clr & ovf_q);
    unf_d = (pop & ~push & empty) | (~clr & unf_q);
    lr = empty ? '0 : mem_q[top_q];
  end
  always_ff @(posedge Clock)
    if (!nReset) begin
      top_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      top_q <= top_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push) mem_q[wr_idx] <= lr_in;
    end
  assign ovf = ovf_q;
  assign unf = unf_q;
endmodule

// File: rtl/datapath_v2.sv
// datapath_v2: CPU datapath (regfile, ALU, PC/IR/ALUOUT, link stack, tristate SysBus).
// Defining DATAPATH_SHADOW_EN adds interrupt shadow PC/Flags restored by Reti.
module datapath_v2
  import datapath_v2_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LS_DEPTH = 4,
  parameter logic [DATA_W-1:0] INT_VEC = DATA_W'(16'h0010)
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic [DATA_W-1:0] DataIn,
  input  dp_ctrl_t          Ctrl,
  output logic [DATA_W-1:0] SysBus,
  output logic [7:0]        Opcode,
  output logic [3:0]        Flags,
  output logic              LsOvf,
  output logic              LsUnf,
  output logic              BusErr
);
  logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d, alu_out_q, alu_out_d;
  logic [DATA_W-1:0] rf_q [8];
  logic [3:0] flags_q, flags_d;
  logic bus_err_q, bus_err_d;
  logic [DATA_W-1:0] imm, op_a, op_b, b_eff, alu_res, bus_val, bus_int, lr, lr_in, pc_inc, wr_data;
  logic [DATA_W:0] sum;
  logic [2:0] rw;
  logic cin, arith, bus_en, unused_ok;
`ifdef DATAPATH_SHADOW_EN
  logic [DATA_W-1:0] sh_pc_q, sh_pc_d;
  logic [3:0] sh_flags_q, sh_flags_d;
`endif
  always_comb begin
    imm = Ctrl.ImmSel == ImmShort ? {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]} : {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    op_a = rf_q[ir_q[7:5]];
    op_b = Ctrl.BSel == BImm ? imm : rf_q[ir_q[4:2]];
    // subtract as a + ~b + 1, so C means "no borrow"
    b_eff = Ctrl.AluFn == AluSub ? ~op_b : op_b;
    cin = Ctrl.AluFn == AluSub ? 1'b1 : Ctrl.AluFn == AluAdc ? flags_q[1] : 1'b0;
    sum = {1'b0, op_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
    arith = Ctrl.AluFn inside {AluAdd, AluAdc, AluSub};
    alu_res = arith ? sum[DATA_W-1:0] : Ctrl.AluFn == AluAnd ? op_a & op_b :
              Ctrl.AluFn == AluOr ? op_a | op_b : Ctrl.AluFn == AluXor ? op_a ^ op_b :
              Ctrl.AluFn == AluPassB ? op_b : op_a >> 1;
    bus_en = nReset & (Ctrl.MemEn | Ctrl.PcEn | Ctrl.LrEn | Ctrl.AluEn);
    bus_val = Ctrl.MemEn ? DataIn : Ctrl.PcEn ? pc_q : Ctrl.LrEn ? lr : alu_out_q;
    bus_int = bus_en ? bus_val : '0;
    pc_inc = pc_q + DATA_W'(1);
    lr_in = Ctrl.LrSel == LrPc1 ? pc_inc : bus_int;
    pc_d = !Ctrl.PcWe ? pc_q : Ctrl.PcSel == PcLr ? lr : Ctrl.PcSel == PcAlu ? alu_res :
           Ctrl.PcSel == PcBus ? bus_int : Ctrl.PcSel == Pc1 ? pc_inc : INT_VEC;
    flags_d = Ctrl.FlagWe ? {alu_res == '0, alu_res[DATA_W-1], arith & sum[DATA_W],
              arith & (op_a[DATA_W-1] == b_eff[DATA_W-1]) & (alu_res[DATA_W-1] != op_a[DATA_W-1])} : flags_q;
`ifdef DATAPATH_SHADOW_EN
    sh_pc_d = Ctrl.PcWe && Ctrl.PcSel == PcInt && !Ctrl.Reti ? pc_q : sh_pc_q;
    sh_flags_d = Ctrl.PcWe && Ctrl.PcSel == PcInt && !Ctrl.Reti ? flags_q : sh_flags_q;
    pc_d = Ctrl.Reti ? sh_pc_q : pc_d;
    flags_d = Ctrl.Reti ? sh_flags_q : flags_d;
`endif
    ir_d = Ctrl.IrWe ? bus_int : ir_q;
    alu_out_d = Ctrl.AluWe ? alu_res : alu_out_q;
    wr_data = Ctrl.WdSel == WdBus ? bus_int : alu_res;
    rw = Ctrl.RwSel == RwR7 ? 3'd7 : Ctrl.RwSel == RwRd ? ir_q[10:8] : ir_q[7:5];
    bus_err_d = ($countones({Ctrl.MemEn, Ctrl.PcEn, Ctrl.LrEn, Ctrl.AluEn}) > 1) | (~Ctrl.LsClr & bus_err_q);
  end
  always_ff @(posedge Clock)
    if (!nReset) begin
      pc_q <= '0;
      ir_q <= '0;
      alu_out_q <= '0;
      flags_q <= '0;
      bus_err_q <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
`ifdef DATAPATH_SHADOW_EN
      sh_pc_q <= '0;
      sh_flags_q <= '0;
`endif
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      alu_out_q <= alu_out_d;
      flags_q <= flags_d;
      bus_err_q <= bus_err_d;
      if (Ctrl.RegWe) rf_q[rw] <= wr_data;
`ifdef DATAPATH_SHADOW_EN
      sh_pc_q <= sh_pc_d;
      sh_flags_q <= sh_flags_d;
`endif
    end
  link_stack #(.DATA_W(DATA_W), .LS_DEPTH(LS_DEPTH)) u_ls (
    .Clock(Clock), .nReset(nReset), .push(Ctrl.LsPush), .pop(Ctrl.LsPop), .clr(Ctrl.LsClr),
    .lr_in(lr_in), .lr(lr), .ovf(LsOvf), .unf(LsUnf)
  );
  assign SysBus = bus_en ? bus_val : 'z;
  assign Opcode = ir_q[15:8];
  assign Flags = flags_q;
  assign BusErr = bus_err_q;
  assign unused_ok = ^{ir_q, Ctrl.Reti};
endmodule

// File: tb/tb_datapath_v2.sv
// tb_datapath_v2: directed tests of datapath_v2 at DATA_W 16, 24 and 32 sharing one control stream.
module tb_datapath_v2;
  import datapath_v2_pkg::*;
  logic clk = 1'b0;
  logic n_reset;
  dp_ctrl_t ctrl;
  logic [31:0] din;
  wire [15:0] bus16;
  wire [23:0] bus24;
  wire [31:0] bus32;
  logic [7:0] op16, op24, op32;
  logic [3:0] fl16, fl24, fl32;
  logic ovf16, unf16, err16, ovf24, unf24, err24, ovf32, unf32, err32;
  int checks = 0;
  int errors = 0;
  pullup (bus16);
  pullup (bus24);
  pullup (bus32);
  datapath_v2 #(.DATA_W(16)) d16 (.Clock(clk), .nReset(n_reset), .DataIn(din[15:0]), .Ctrl(ctrl), .SysBus(bus16),
    .Opcode(op16), .Flags(fl16), .LsOvf(ovf16), .LsUnf(unf16), .BusErr(err16));
  datapath_v2 #(.DATA_W(24)) d24 (.Clock(clk), .nReset(n_reset), .DataIn(din[23:0]), .Ctrl(ctrl), .SysBus(bus24),
    .Opcode(op24), .Flags(fl24), .LsOvf(ovf24), .LsUnf(unf24), .BusErr(err24));
  datapath_v2 #(.DATA_W(32)) d32 (.Clock(clk), .nReset(n_reset), .DataIn(din), .Ctrl(ctrl), .SysBus(bus32),
    .Opcode(op32), .Flags(fl32), .LsOvf(ovf32), .LsUnf(unf32), .BusErr(err32));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic [15:0] v, input logic also_pop);
    ctrl = '0; ctrl.MemEn = 1; ctrl.LrSel = LrBus; ctrl.LsPush = 1; ctrl.LsPop = also_pop; din = {16'h0, v};
    tick();
    ctrl = '0;
  endtask

  task automatic test_reset();
    n_reset = 0; ctrl = '0; ctrl.PcWe = 1; ctrl.PcSel = Pc1; ctrl.PcEn = 1; ctrl.FlagWe = 1; ctrl.LsPush = 1; din = 32'h1234;
    tick(); tick();
    checks++; if (d32.pc_q !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", d32.pc_q); end
    checks++; if (fl32 !== 4'd0) begin errors++; $display("FAIL reset_flags got %b want 0000", fl32); end
    checks++; if (bus32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_bus_z got %h want pulled-up ffffffff", bus32); end
    checks++; if ({ovf32, unf32, err32} !== 3'b000) begin errors++; $display("FAIL reset_sticky got %b want 000", {ovf32, unf32, err32}); end
    checks++; if (d16.u_ls.count_q !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", d16.u_ls.count_q); end
    n_reset = 1; ctrl = '0; ctrl.PcWe = 1; ctrl.PcSel = Pc1;
    repeat (3) tick();
    ctrl = '0; ctrl.PcEn = 1; #1;
    checks++; if (bus32 !== 32'd3) begin errors++; $display("FAIL pc_inc3 got %h want 3", bus32); end
    ctrl = '0;
  endtask

  task automatic test_alu();
    ctrl = '0; ctrl.MemEn = 1; ctrl.IrWe = 1; din = 32'h0121; tick();
    ctrl = '0; ctrl.MemEn = 1; ctrl.RegWe = 1; ctrl.RwSel = RwRd; ctrl.WdSel = WdBus; din = 32'hFFFF; tick();
    ctrl = '0; ctrl.AluFn = AluAdd; ctrl.BSel = BImm; ctrl.FlagWe = 1; ctrl.AluWe = 1; tick();
    checks++; if (op16 !== 8'h01) begin errors++; $display("FAIL opcode got %h want 01", op16); end
    checks++; if (fl16 !== 4'b1010) begin errors++; $display("FAIL add16_flags got %b want 1010", fl16); end
    checks++; if (fl24 !== 4'b0000) begin errors++; $display("FAIL add24_flags got %b want 0000", fl24); end
    ctrl = '0; ctrl.AluEn = 1; #1;
    checks++; if (bus16 !== 16'h0000) begin errors++; $display("FAIL add16_res got %h want 0000", bus16); end
    checks++; if (bus24 !== 24'h010000) begin errors++; $display("FAIL add24_res got %h want 010000", bus24); end
    ctrl = '0; ctrl.AluFn = AluSub; ctrl.BSel = BImm; ctrl.FlagWe = 1; tick();
    checks++; if (fl16 !== 4'b0110) begin errors++; $display("FAIL sub16_flags got %b want 0110", fl16); end
    checks++; if (fl24 !== 4'b0010) begin errors++; $display("FAIL sub24_flags got %b want 0010", fl24); end
    ctrl = '0; ctrl.AluFn = AluAdc; ctrl.BSel = BImm; ctrl.FlagWe = 1; ctrl.AluWe = 1; tick();
    ctrl = '0; ctrl.AluEn = 1; #1;
    checks++; if (bus16 !== 16'h0001) begin errors++; $display("FAIL adc16_res got %h want 0001", bus16); end
    checks++; if (fl16 !== 4'b0010) begin errors++; $display("FAIL adc16_flags got %b want 0010", fl16); end
    ctrl = '0; ctrl.AluFn = AluAnd; tick();
    checks++; if (fl16 !== 4'b0010) begin errors++; $display("FAIL flags_hold got %b want 0010", fl16); end
    ctrl = '0;
  endtask

  task automatic test_pc();
    ctrl = '0; ctrl.PcWe = 1; ctrl.PcSel = PcInt; tick();
    ctrl = '0; ctrl.PcEn = 1; #1;
    checks++; if (bus16 !== 16'h0010) begin errors++; $display("FAIL pc_int got %h want 0010", bus16); end
    ctrl = '0; ctrl.MemEn = 1; ctrl.PcWe = 1; ctrl.PcSel = PcBus; din = 32'hFFFF; tick();
    ctrl = '0; ctrl.PcWe = 1; ctrl.PcSel = Pc1; tick();
    ctrl = '0; ctrl.PcEn = 1; #1;
    checks++; if (bus16 !== 16'h0000) begin errors++; $display("FAIL pc_wrap16 got %h want 0000", bus16); end
    checks++; if (bus32 !== 32'h0001_0000) begin errors++; $display("FAIL pc_inc32 got %h want 00010000", bus32); end
    push_bus(16'h0055, 1'b0);
    ctrl = '0; ctrl.PcWe = 1; ctrl.PcSel = PcLr; ctrl.LsPop = 1; tick();
    ctrl = '0; ctrl.PcEn = 1; #1;
    checks++; if (bus16 !== 16'h0055) begin errors++; $display("FAIL pc_lr got %h want 0055", bus16); end
    ctrl = '0;
  endtask

  task automatic test_link_stack();
    logic [15:0] v [5];
    v = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h55};
    for (int i = 0; i < 5; i++) push_bus(v[i], 1'b0);
    checks++; if (ovf16 !== 1'b1) begin errors++; $display("FAIL ls_ovf got %b want 1", ovf16); end
    checks++; if (d16.u_ls.count_q !== 3'd4) begin errors++; $display("FAIL ls_full_count got %0d want 4", d16.u_ls.count_q); end
    for (int i = 4; i >= 1; i--) begin
      ctrl = '0; ctrl.LrEn = 1; #1;
      checks++; if (bus16 !== v[i]) begin errors++; $display("FAIL ls_pop%0d got %h want %h", i, bus16, v[i]); end
      ctrl.LsPop = 1; tick();
    end
    ctrl = '0; ctrl.LsPop = 1; tick();
    ctrl = '0; ctrl.LrEn = 1; #1;
    checks++; if (unf16 !== 1'b1) begin errors++; $display("FAIL ls_unf got %b want 1", unf16); end
    checks++; if (bus16 !== 16'h0000) begin errors++; $display("FAIL ls_empty_lr got %h want 0000", bus16); end
    checks++; if (d16.u_ls.count_q !== 3'd0) begin errors++; $display("FAIL ls_empty_count got %0d want 0", d16.u_ls.count_q); end
    ctrl = '0; ctrl.LsClr = 1; tick();
    checks++; if ({ovf16, unf16} !== 2'b00) begin errors++; $display("FAIL ls_clr got %b want 00", {ovf16, unf16}); end
    ctrl = '0;
  endtask

  task automatic test_push_pop();
    push_bus(16'h0011, 1'b0);
    push_bus(16'h0022, 1'b0);
    push_bus(16'h0099, 1'b1);
    ctrl = '0; ctrl.LrEn = 1; #1;
    checks++; if (bus16 !== 16'h0099) begin errors++; $display("FAIL pp_top got %h want 0099", bus16); end
    checks++; if (d16.u_ls.count_q !== 3'd2) begin errors++; $display("FAIL pp_count got %0d want 2", d16.u_ls.count_q); end
    checks++; if ({ovf16, unf16} !== 2'b00) begin errors++; $display("FAIL pp_flags got %b want 00", {ovf16, unf16}); end
    ctrl.LsPop = 1; tick();
    ctrl = '0; ctrl.LrEn = 1; #1;
    checks++; if (bus16 !== 16'h0011) begin errors++; $display("FAIL pp_below got %h want 0011", bus16); end
    ctrl.LsPop = 1; tick();
    push_bus(16'h0077, 1'b1);
    ctrl = '0; ctrl.LrEn = 1; #1;
    checks++; if (bus16 !== 16'h0077 || d16.u_ls.count_q !== 3'd1 || unf16 !== 1'b0) begin
      errors++; $display("FAIL pp_empty got lr %h count %0d unf %b want 0077 1 0", bus16, d16.u_ls.count_q, unf16);
    end
    ctrl = '0; ctrl.LsPop = 1; tick();
    ctrl = '0;
  endtask

  task automatic test_bus_err();
    ctrl = '0; ctrl.PcEn = 1; ctrl.AluEn = 1; tick();
    ctrl = '0;
    checks++; if (err16 !== 1'b1) begin errors++; $display("FAIL buserr_set got %b want 1", err16); end
    tick();
    checks++; if (err16 !== 1'b1) begin errors++; $display("FAIL buserr_sticky got %b want 1", err16); end
    ctrl = '0; ctrl.LsClr = 1; tick();
    checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL buserr_clr got %b want 0", err16); end
    ctrl = '0; ctrl.LsClr = 1; ctrl.MemEn = 1; ctrl.LrEn = 1; tick();
    checks++; if (err16 !== 1'b1) begin errors++; $display("FAIL buserr_set_wins got %b want 1", err16); end
    ctrl = '0; ctrl.LsClr = 1; tick();
    ctrl = '0;
  endtask

  task automatic test_shadow();
    ctrl = '0; ctrl.MemEn = 1; ctrl.PcWe = 1; ctrl.PcSel = PcBus; din = 32'h0123; tick();
`ifdef DATAPATH_SHADOW_EN
    ctrl = '0; ctrl.MemEn = 1; ctrl.RegWe = 1; ctrl.RwSel = RwRd; ctrl.WdSel = WdBus; din = 32'h7FFF; tick();
    ctrl = '0; ctrl.AluFn = AluAdd; ctrl.BSel = BImm; ctrl.FlagWe = 1; tick();
    checks++; if (fl16 !== 4'b0101) begin errors++; $display("FAIL sh_pre_flags got %b want 0101", fl16); end
    ctrl = '0; ctrl.PcWe = 1; ctrl.PcSel = PcInt; tick();
    ctrl = '0; ctrl.PcEn = 1; #1;
    checks++; if (bus16 !== 16'h0010) begin errors++; $display("FAIL sh_int_pc got %h want 0010", bus16); end
    ctrl = '0; ctrl.AluFn = AluSub; ctrl.BSel = BImm; ctrl.FlagWe = 1; tick();
    checks++; if (fl16 !== 4'b0010) begin errors++; $display("FAIL sh_alt_flags got %b want 0010", fl16); end
    ctrl = '0; ctrl.Reti = 1; ctrl.PcWe = 1; ctrl.PcSel = Pc1; ctrl.FlagWe = 1; ctrl.AluFn = AluSub; ctrl.BSel = BImm; tick();
    ctrl = '0; ctrl.PcEn = 1; #1;
    checks++; if (bus16 !== 16'h0123) begin errors++; $display("FAIL sh_reti_pc got %h want 0123", bus16); end
    checks++; if (fl16 !== 4'b0101) begin errors++; $display("FAIL sh_reti_flags got %b want 0101", fl16); end
`else
    ctrl = '0; ctrl.Reti = 1; tick();
    ctrl = '0; ctrl.PcEn = 1; #1;
    checks++; if (bus16 !== 16'h0123) begin errors++; $display("FAIL reti_ignored got %h want 0123", bus16); end
`endif
    ctrl = '0;
  endtask

  initial begin
    ctrl = '0;
    din = '0;
    n_reset = 0;
    test_reset();
    test_alu();
    test_pc();
    test_link_stack();
    test_push_pop();
    test_bus_err();
    test_shadow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/datapath_v2.md
DATAPATH_V2 -- requirements
Module: datapath_v2

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning datapath width (legal: 16, 24, 32).
REQ-002 SHALL have parameter LS_DEPTH, default 4, meaning link-stack entries (power of 2, 2..16).
REQ-003 SHALL have parameter INT_VEC, default 16'h0010 zero-extended to DATA_W, meaning interrupt PC vector.
REQ-004 SHALL have ports (name direction width meaning):
- Clock  in  1  sole clock, rising edge.
- nReset  in  1  synchronous, active-low reset.
- DataIn  in  DATA_W  memory read data.
- Ctrl  in  dp_ctrl_t  all select and enable strobes from the control unit.
- SysBus  out  DATA_W  tristate system bus.
- Opcode  out  8  Ir[15:8].
- Flags  out  4  registered {Z,N,C,V}.
- LsOvf  out  1  sticky link-stack overflow.
- LsUnf  out  1  sticky link-stack underflow.
- BusErr  out  1  sticky multiple-driver error.

Function
REQ-005 SHALL decode instruction fields from Ir[15:0] only: Rd=Ir[10:8], Ra=Ir[7:5], Rb=Ir[4:2]; Ir[DATA_W-1:16] SHALL be ignored.
REQ-006 SHALL sign-extend the immediate to DATA_W: Ir[4:0] when ImmSel=ImmShort, else Ir[7:0].
REQ-007 SHALL contain 8 x DATA_W registers: 2 combinational reads, 1 write on the Clock edge when RegWe=1; Rw is 7, Rd or Ra per RwSel.
REQ-008 SHALL implement the combinational ALU for all alu_functions_t values at DATA_W width; carry-in SHALL come from registered Flags.C.
REQ-009 SHALL update Flags from the ALU on the edge where FlagWe=1, otherwise hold.
REQ-010 SHALL load PC when PcWe=1 from Lr, AluRes, SysBus, Pc+1 (mod 2^DATA_W) or INT_VEC, selected by PcSel.
REQ-011 SHALL load IR from SysBus when IrWe=1, and ALUOUT from AluRes when AluWe=1.
REQ-012 SHALL drive SysBus from DataIn, PC, Lr or ALUOUT when MemEn, PcEn, LrEn or AluEn is respectively 1, else high-Z.
REQ-013 SHALL set BusErr on the edge after any cycle with more than one of MemEn/PcEn/LrEn/AluEn high; the bus value in that cycle is undefined.
REQ-014 SHALL expose the link stack as a circular buffer with count 0..LS_DEPTH; Lr equals top entry, or 0 when count is 0.
REQ-015 On LsPush alone, SHALL write LrIn (Pc+1 or SysBus per LrSel) as the new top, count+1; when count=LS_DEPTH it SHALL overwrite the oldest entry, keep count, and set LsOvf.
REQ-016 On LsPop alone, SHALL remove the top entry, count-1; when count=0, count SHALL stay 0, Lr SHALL stay 0, and LsUnf SHALL be set.
REQ-017 On LsPush and LsPop in the same cycle, SHALL replace the top with LrIn, count unchanged; if count=0 this SHALL act as a plain push.
REQ-018 SHALL clear LsOvf, LsUnf and BusErr on the edge where LsClr=1; a set condition in the same cycle SHALL win.
REQ-019 Every state update (PC, IR, ALUOUT, Flags, register file, link stack) SHALL take effect on the next Clock edge; latency is 1 cycle.

Reset
REQ-020 While nReset=0 at a Clock edge: PC, IR, ALUOUT, Flags, stack count, LsOvf, LsUnf and BusErr SHALL be 0, and all register-file entries SHALL be 0.
REQ-021 Reset SHALL override all Ctrl strobes in the same cycle; SysBus SHALL be high-Z while nReset=0.

Configuration
REQ-022 With DATAPATH_SHADOW_EN defined: a PC load with PcSel=PcInt SHALL copy the pre-load PC and Flags into shadow registers on the same edge.
REQ-023 With DATAPATH_SHADOW_EN defined: Reti=1 SHALL restore PC and Flags from the shadows in one edge, overriding PcWe and FlagWe; shadows SHALL reset to 0.
REQ-024 Without DATAPATH_SHADOW_EN: no shadow registers SHALL exist, Reti SHALL be ignored, and PcInt SHALL only load INT_VEC.

Structure
REQ-025 The opcodes package SHALL hold dp_ctrl_t (a packed struct of all selects and strobes, including FlagWe, LsPush, LsPop, LsClr and Reti) and the new select enums.
REQ-026 The link stack SHALL be the sub-module link_stack, parametrised by DATA_W and LS_DEPTH.
REQ-027 The register file, ALU and muxes SHALL be inline in datapath_v2.

Verification
REQ-028 Reset with DATA_W=32: PC=0, Flags=0, SysBus=Z -> release, PcSel=Pc1, PcWe for 3 cycles -> PC=3.
REQ-029 LS_DEPTH=4: push 0x11,0x22,0x33,0x44,0x55 -> LsOvf=1, count=4, then pops return 0x55,0x44,0x33,0x22, and a 5th pop -> LsUnf=1 with Lr=0.
REQ-030 Count=2 with top 0x22, push 0x99 and pop in the same cycle -> top=0x99, count=2, no flags.
REQ-031 PcEn and AluEn high in one cycle -> BusErr=1 next cycle; LsClr -> BusErr=0.
REQ-032 With DATAPATH_SHADOW_EN: PC=0x0123, Flags=4'b0101, take interrupt -> PC=INT_VEC; alter Flags, then Reti -> PC=0x0123, Flags=4'b0101.
REQ-033 ALU add 16'hFFFF+1 with FlagWe=1 at DATA_W=16 -> Z=1, C=1; at DATA_W=24 -> result 24'h010000, Z=0.
